// File: rtl/pixel_dispatch_pkg.sv
// Shared definitions for the pixel dispatcher.
// Holds the row-to-solver mapping mode encodings and the control FSM state type.
package pixel_dispatch_pkg;

   localparam logic MODE_BROADCAST  = 1'b0;
   localparam logic MODE_INTERLEAVE = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/pixel_dispatcher_wrap_counter.sv
// wrap_counter: up-counter that returns to zero after reaching a runtime limit.
// Ports:
//   clock, reset : posedge clock, synchronous active-high reset
//   clr          : force the count to zero (wins over inc)
//   inc          : advance by one
//   limit        : last value before wrapping (count range 0..limit)
//   count        : current value
//   at_limit     : count == limit
//   wrap         : inc while at_limit, i.e. the count returns to zero this cycle
module wrap_counter
   import pixel_dispatch_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] count,
   output logic             at_limit,
   output logic             wrap
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      at_limit = (count_q == limit);
      wrap     = inc && at_limit;
      count_d  = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc) begin
         count_d = at_limit ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pixel_dispatcher.sv
// pixel_dispatcher: walks a runtime-sized frame and issues one beat per
// accepted valid/ready handshake to the solver array.
// Ports:
//   clock, reset           : posedge clock, synchronous active-high reset
//   start, abort           : frame control pulses
//   cfg_columns/rows/mode  : frame geometry and mapping mode, latched at start
//   out_valid, out_ready   : beat handshake
//   solver_id, solver_addr, pixel_x, pixel_y : beat payload
//   start_stream, end_line, end_stream       : beat framing flags
//   busy, done             : frame in progress / one-cycle completion pulse
// Scan order:
//   broadcast : for y, for solver, for x  (each row replayed to every solver)
//   interleave: for y, for x with solver = y mod NUM_SOLVERS
module pixel_dispatcher
   import pixel_dispatch_pkg::*;
#(
   parameter  int NUM_SOLVERS = 4,
   parameter  int MAX_COLUMNS = 1024,
   parameter  int MAX_ROWS    = 768,
   parameter  int ID_WIDTH    = 6,
   parameter  int ADDR_WIDTH  = 20,
   localparam int COL_W       = $clog2(MAX_COLUMNS + 1),
   localparam int ROW_W       = $clog2(MAX_ROWS + 1)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic [COL_W-1:0]      cfg_columns,
   input  logic [ROW_W-1:0]      cfg_rows,
   input  logic                  cfg_mode,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ID_WIDTH-1:0]   solver_id,
   output logic [ADDR_WIDTH-1:0] solver_addr,
   output logic [COL_W-1:0]      pixel_x,
   output logic [ROW_W-1:0]      pixel_y,
   output logic                  start_stream,
   output logic                  end_line,
   output logic                  end_stream,
   output logic                  busy,
   output logic                  done
);

   state_t                state_q, state_d;
   logic [COL_W-1:0]      cols_q, cols_d;
   logic [ROW_W-1:0]      rows_q, rows_d;
   logic                  mode_q, mode_d;
   logic [ADDR_WIDTH-1:0] line_base_q, line_base_d;

   logic [COL_W-1:0]      cols_clamped;
   logic [ROW_W-1:0]      rows_clamped;
   logic                  running;
   logic                  fire;
   logic                  cnt_clr;
   logic                  last_beat;

   logic [COL_W-1:0]      x_cnt;
   logic [ID_WIDTH-1:0]   s_cnt;
   logic [ROW_W-1:0]      y_cnt;
   logic                  x_last, s_last, y_last;
   logic                  x_wrap, s_wrap, y_wrap;
   logic                  y_inc;

   assign running = (state_q == RUN);
   // abort beats a coincident handshake, so the beat is never consumed
   assign fire    = running && out_ready && !abort;
   // counters sit at zero outside a frame so every restart is fresh
   assign cnt_clr = !running || abort;

   // solver index steps on every row segment end in both modes:
   // broadcast replays the row per solver, interleave moves to the next row
   // whose solver is the next one modulo NUM_SOLVERS
   assign y_inc = (mode_q == MODE_INTERLEAVE) ? x_wrap : s_wrap;

   wrap_counter #(.WIDTH(COL_W)) u_x_cnt (
      .clock    (clock),
      .reset    (reset),
      .clr      (cnt_clr),
      .inc      (fire),
      .limit    (cols_q - 1'b1),
      .count    (x_cnt),
      .at_limit (x_last),
      .wrap     (x_wrap)
   );

   wrap_counter #(.WIDTH(ID_WIDTH)) u_s_cnt (
      .clock    (clock),
      .reset    (reset),
      .clr      (cnt_clr),
      .inc      (x_wrap),
      .limit    (ID_WIDTH'(NUM_SOLVERS - 1)),
      .count    (s_cnt),
      .at_limit (s_last),
      .wrap     (s_wrap)
   );

   wrap_counter #(.WIDTH(ROW_W)) u_y_cnt (
      .clock    (clock),
      .reset    (reset),
      .clr      (cnt_clr),
      .inc      (y_inc),
      .limit    (rows_q - 1'b1),
      .count    (y_cnt),
      .at_limit (y_last),
      .wrap     (y_wrap)
   );

   assign last_beat = x_last && y_last && ((mode_q == MODE_INTERLEAVE) || s_last);

   always_comb begin
      cols_clamped = (cfg_columns > COL_W'(MAX_COLUMNS)) ? COL_W'(MAX_COLUMNS) : cfg_columns;
      rows_clamped = (cfg_rows > ROW_W'(MAX_ROWS)) ? ROW_W'(MAX_ROWS) : cfg_rows;
   end

   always_comb begin
      state_d = state_q;
      cols_d  = cols_q;
      rows_d  = rows_q;
      mode_d  = mode_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               cols_d  = cols_clamped;
               rows_d  = rows_clamped;
               mode_d  = cfg_mode;
               state_d = ((cols_clamped == '0) || (rows_clamped == '0)) ? DONE : RUN;
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
            end else if (fire && last_beat) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // running row start address; a row step adds one frame width
   always_comb begin
      line_base_d = line_base_q;
      if (cnt_clr) begin
         line_base_d = '0;
      end else if (y_inc) begin
         line_base_d = line_base_q + ADDR_WIDTH'(cols_q);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         cols_q      <= '0;
         rows_q      <= '0;
         mode_q      <= MODE_BROADCAST;
         line_base_q <= '0;
      end else begin
         state_q     <= state_d;
         cols_q      <= cols_d;
         rows_q      <= rows_d;
         mode_q      <= mode_d;
         line_base_q <= line_base_d;
      end
   end

   // payload is a pure function of registered state, so it holds during stalls
   assign out_valid    = running;
   assign busy         = running;
   assign done         = (state_q == DONE);
   assign solver_id    = s_cnt;
   assign pixel_x      = x_cnt;
   assign pixel_y      = y_cnt;
   assign solver_addr  = line_base_q + ADDR_WIDTH'(x_cnt);
   assign start_stream = running && (x_cnt == '0) && (y_cnt == '0) && (s_cnt == '0);
   assign end_line     = running && x_last;
   assign end_stream   = running && last_beat;

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Directed bench for pixel_dispatcher with a beat scoreboard.
module tb_pixel_dispatcher;

   localparam int NS    = 2;
   localparam int MAXC  = 8;
   localparam int MAXR  = 8;
   localparam int IDW   = 6;
   localparam int AW    = 8;
   localparam int CW    = $clog2(MAXC + 1);
   localparam int RW    = $clog2(MAXR + 1);
   localparam int SNAPW = IDW + AW + CW + RW + 3;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic            start = 1'b0;
   logic            abort = 1'b0;
   logic [CW-1:0]   cfg_columns = '0;
   logic [RW-1:0]   cfg_rows = '0;
   logic            cfg_mode = 1'b0;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic [IDW-1:0]  solver_id;
   logic [AW-1:0]   solver_addr;
   logic [CW-1:0]   pixel_x;
   logic [RW-1:0]   pixel_y;
   logic            start_stream, end_line, end_stream, busy, done;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int id, addr, x, y;
      bit ss, el, es;
   } beat_t;

   beat_t exp_q[$];

   pixel_dispatcher #(
      .NUM_SOLVERS(NS), .MAX_COLUMNS(MAXC), .MAX_ROWS(MAXR),
      .ID_WIDTH(IDW), .ADDR_WIDTH(AW)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .abort(abort),
      .cfg_columns(cfg_columns), .cfg_rows(cfg_rows), .cfg_mode(cfg_mode),
      .out_valid(out_valid), .out_ready(out_ready),
      .solver_id(solver_id), .solver_addr(solver_addr),
      .pixel_x(pixel_x), .pixel_y(pixel_y),
      .start_stream(start_stream), .end_line(end_line), .end_stream(end_stream),
      .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [SNAPW-1:0] snap();
      return {solver_id, solver_addr, pixel_x, pixel_y, start_stream, end_line, end_stream};
   endfunction

   // reference scan order, with addresses from a direct multiply
   task automatic push_frame(input int c, input int r, input bit m);
      int cc, rr;
      beat_t b;
      cc = (c > MAXC) ? MAXC : c;
      rr = (r > MAXR) ? MAXR : r;
      for (int y = 0; y < rr; y++) begin
         for (int s = 0; s < (m ? 1 : NS); s++) begin
            for (int x = 0; x < cc; x++) begin
               b.id   = m ? (y % NS) : s;
               b.addr = y * cc + x;
               b.x    = x;
               b.y    = y;
               b.ss   = (x == 0) && (y == 0) && (s == 0);
               b.el   = (x == cc - 1);
               b.es   = (x == cc - 1) && (y == rr - 1) && (m || s == NS - 1);
               exp_q.push_back(b);
            end
         end
      end
   endtask

   task automatic check_beat();
      beat_t e;
      chk("valid", 32'(out_valid), 1);
      chk("busy", 32'(busy), 1);
      if (exp_q.size() == 0) begin
         chk("extra_beat", 32'(solver_addr), 32'hFFFF_FFFF);
      end else begin
         e = exp_q.pop_front();
         chk("id", 32'(solver_id), e.id);
         chk("addr", 32'(solver_addr), e.addr);
         chk("x", 32'(pixel_x), e.x);
         chk("y", 32'(pixel_y), e.y);
         chk("start_stream", 32'(start_stream), 32'(e.ss));
         chk("end_line", 32'(end_line), 32'(e.el));
         chk("end_stream", 32'(end_stream), 32'(e.es));
      end
   endtask

   task automatic run_frame(input int c, input int r, input bit m, input bit stall, input bit poke);
      int cyc;
      bit held;
      logic [SNAPW-1:0] s0;
      push_frame(c, r, m);
      @(negedge clock);
      cfg_columns = CW'(c);
      cfg_rows    = RW'(r);
      cfg_mode    = m;
      out_ready   = 1'b1;
      start       = 1'b1;
      @(negedge clock);
      start = 1'b0;
      cyc   = 0;
      held  = 0;
      s0    = '0;
      while (exp_q.size() > 0 && cyc < 2000) begin
         if (held) begin
            chk("stall_hold", 32'(snap()), 32'(s0));
            chk("stall_valid", 32'(out_valid), 1);
         end
         out_ready   = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
         start       = poke && (cyc == 3);
         cfg_columns = (poke && cyc == 3) ? CW'(2) : CW'(c);
         held        = 0;
         if (out_valid && out_ready) begin
            check_beat();
         end else begin
            chk("valid_run", 32'(out_valid), 1);
            held = 1;
            s0   = snap();
         end
         cyc++;
         @(negedge clock);
      end
      start     = 1'b0;
      out_ready = 1'b1;
      chk("drained", exp_q.size(), 0);
      exp_q.delete();
      chk("done_pulse", 32'(done), 1);
      chk("valid_after", 32'(out_valid), 0);
      chk("busy_after", 32'(busy), 0);
      @(negedge clock);
      chk("done_clear", 32'(done), 0);
      chk("busy_idle", 32'(busy), 0);
   endtask

   initial begin
      // reset
      repeat (2) @(negedge clock);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_flags", 32'({start_stream, end_line, end_stream}), 0);
      chk("rst_payload", 32'({solver_id, solver_addr, pixel_x, pixel_y}), 0);
      reset = 1'b0;
      @(negedge clock);

      // 4x3 interleave, 3x2 broadcast, no stalls
      run_frame(4, 3, 1'b1, 1'b0, 1'b0);
      run_frame(3, 2, 1'b0, 1'b0, 1'b0);

      // same frames under random backpressure
      run_frame(4, 3, 1'b1, 1'b1, 1'b0);
      run_frame(3, 2, 1'b0, 1'b1, 1'b0);

      // abort coincident with the handshake of beat 5
      push_frame(4, 3, 1'b1);
      @(negedge clock);
      cfg_columns = CW'(4);
      cfg_rows    = RW'(3);
      cfg_mode    = 1'b1;
      out_ready   = 1'b1;
      start       = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check_beat();
         @(negedge clock);
      end
      chk("abort_beat_valid", 32'(out_valid), 1);
      chk("abort_beat_addr", 32'(solver_addr), 5);
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      exp_q.delete();
      chk("abort_valid", 32'(out_valid), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_done", 32'(done), 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk("abort_no_done", 32'(done), 0);
         chk("abort_idle_valid", 32'(out_valid), 0);
      end
      run_frame(4, 3, 1'b1, 1'b0, 1'b0);

      // zero width: done next cycle, no beats
      @(negedge clock);
      cfg_columns = '0;
      cfg_rows    = RW'(3);
      cfg_mode    = 1'b1;
      start       = 1'b1;
      @(negedge clock);
      start = 1'b0;
      chk("zero_done", 32'(done), 1);
      chk("zero_busy", 32'(busy), 0);
      chk("zero_valid", 32'(out_valid), 0);
      @(negedge clock);
      chk("zero_done_clear", 32'(done), 0);
      chk("zero_valid_idle", 32'(out_valid), 0);

      // single pixel
      run_frame(1, 1, 1'b1, 1'b0, 1'b0);

      // width clamped to MAXC, with a start poked mid-frame
      run_frame(MAXC + 5, 2, 1'b1, 1'b0, 1'b1);
      run_frame(MAXC + 5, 1, 1'b0, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pixel_dispatcher.md
# pixel_dispatcher

Frame-scan pixel dispatcher for the fractal renderer. Walks a runtime-configurable frame and issues one (solver_id, linear address, x, y) beat per accepted handshake to the solver array. Parametrised successor to the fixed 640x480 enable-driven iterator. Adds a valid/ready output handshake, start/busy/done control, abort, and a selectable row-to-solver mapping mode. Sits between the frame controller and the solver request fan-out.

## Interface

Parameters:

- NUM_SOLVERS, 4, number of solvers; 1..2^ID_WIDTH
- MAX_COLUMNS, 1024, largest supported frame width
- MAX_ROWS, 768, largest supported frame height
- ID_WIDTH, 6, solver_id width
- ADDR_WIDTH, 20, solver_addr width; must satisfy 2^ADDR_WIDTH >= MAX_COLUMNS*MAX_ROWS
- Derived localparams:
  - COL_W = $clog2(MAX_COLUMNS+1)
  - ROW_W = $clog2(MAX_ROWS+1)

Ports:

- clock, in, 1, single clock; everything is posedge
- reset, in, 1, synchronous, active-high
- start, in, 1, pulse; begins a frame when idle
- abort, in, 1, pulse; terminates the frame in progress
- cfg_columns, in, COL_W, frame width; sampled at accepted start
- cfg_rows, in, ROW_W, frame height; sampled at accepted start
- cfg_mode, in, 1, 0 = broadcast, 1 = interleave; sampled at accepted start
- out_valid, out, 1, beat available
- out_ready, in, 1, consumer accepts the beat
- solver_id, out, ID_WIDTH, target solver
- solver_addr, out, ADDR_WIDTH, y*columns + x
- pixel_x, out, COL_W, column
- pixel_y, out, ROW_W, row
- start_stream, out, 1, first beat of the frame
- end_line, out, 1, last beat of a row segment (x == columns-1)
- end_stream, out, 1, last beat of the frame
- busy, out, 1, frame in progress
- done, out, 1, one-cycle pulse on normal frame completion

## Operation

- States:
  - IDLE -> RUN on start with nonzero dimensions.
  - IDLE -> DONE on start with either dimension zero.
  - RUN -> DONE on handshake of the end_stream beat.
  - RUN -> IDLE on abort.
  - DONE -> IDLE unconditionally.
- Config is latched on the accepted start. Values above MAX_COLUMNS or MAX_ROWS are clamped to the maximum.
- start is ignored while busy.
- Broadcast mode (0): the scan order is for y, for s in 0..NUM_SOLVERS-1, for x. Each row is issued once to every solver. Total beats = rows*columns*NUM_SOLVERS.
- Interleave mode (1): the scan order is for y, for x. solver_id = y mod NUM_SOLVERS, kept as a wrapping counter with no divider. Total beats = rows*columns.
- solver_addr is computed incrementally as line_base + x. line_base advances by columns on each row change; no multiplier is used. Arithmetic wraps modulo 2^ADDR_WIDTH, which is unreachable under the parameter constraint.
- A beat advances only on out_valid && out_ready.
- While out_valid && !out_ready, every output is held stable.
- Flag rules:
  - start_stream is set only on beat (0,0) for solver 0.
  - end_line is set on every x == columns-1 beat, including the final beat.
  - end_stream is set only on the final beat.
- abort takes priority over a simultaneous handshake.
- reset takes priority over everything.

## Timing

- Reset values: out_valid 0, busy 0, done 0, all flags 0, solver_id/solver_addr/pixel_x/pixel_y 0, state IDLE.
- Start latency: start accepted at cycle t gives out_valid=1 and busy=1 at t+1, carrying the first beat.
- Throughput is one beat per cycle while out_ready stays high.
- Completion: final beat accepted at T gives out_valid=0, busy=0, done=1 at T+1 and IDLE at T+2. start is honoured from T+2.
- Zero-dimension start at t gives done=1 at t+1 with no beats. busy stays 0.
- Abort or reset mid-frame at t gives out_valid=0 and busy=0 at t+1, with no done pulse. The next start runs a full fresh frame.
- Single-pixel frame (1x1, interleave): that beat has start_stream, end_line and end_stream all set.

## Structure

- Package pixel_dispatch_pkg holds:
  - MODE_BROADCAST = 1'b0 and MODE_INTERLEAVE = 1'b1
  - the state enum {IDLE, RUN, DONE}
- One sub-module: wrap_counter, a parametrised-width counter with inc, limit and wrap outputs. It is instantiated three times: x, solver index and y.

## Test plan

- 4x3 interleave, NUM_SOLVERS=2, out_ready=1: 12 beats.
  - solver_id sequence 0,0,0,0,1,1,1,1,0,0,0,0.
  - addr 0..11.
  - end_line on addr 3, 7 and 11.
  - done at final+1.
- 3x2 broadcast, NUM_SOLVERS=2: 12 beats.
  - addr 0,1,2 (s0), 0,1,2 (s1), then 3,4,5 (s0), 3,4,5 (s1).
  - end_stream only on the last addr-5 beat.
- Random out_ready stall pattern: outputs are stable during every stall, no beat is lost or duplicated, and the addr sequence matches the no-stall run.
- Abort asserted on beat 5 concurrently with a handshake: out_valid and busy drop next cycle and done never pulses. A restart then begins at addr 0 with start_stream set.
- cfg_columns=0: done pulses 1 cycle after start with no beats. Separately, a 1x1 frame produces a single beat with all three flags set.
- cfg_columns=MAX_COLUMNS+5 is clamped: the last beat of row 0 has addr MAX_COLUMNS-1. A start asserted mid-frame is ignored.
